forwarding_hazard_unit: RTL and testbench
=========================================

# forwarding_hazard_unit

Parametrised data-hazard unit for the in-order integer pipeline, sitting beside the decode stage. It tracks the destination registers of the last `FWD_DEPTH` instructions past decode and selects a forwarding source per decode operand, youngest producer first. When a load result is not ready yet, it inserts a load-use stall and injects a bubble into execute. Compared with the earlier hazard block, it adds:
- valid, write-enable and x0 qualification;
- correct bubble tracking;
- flush and global hold;
- a configurable load-data stage;
- an optional stall counter.

## Interface
Parameters:
- `REGISTER_SIZE`, 5, register index width.
- `FWD_DEPTH`, 3, tracked stages after decode (1 = execute, 2 = memory access, 3 = writeback); must be ≥1.
- `LOAD_STAGE`, 2, first stage index at which load data is forwardable; 1 ≤ `LOAD_STAGE` ≤ `FWD_DEPTH`.
- `COUNT_W`, 16, stall counter width.
- Derived: `STAGE_W` = $clog2(`FWD_DEPTH`+1).

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high, sampled on `posedge clk`.
- `rst` in 1: synchronous active-high reset.
- `decode_valid` in 1: decode stage holds a real instruction.
- `destination_reg` in `REGISTER_SIZE`: decode rd.
- `rd_write_en` in 1: decode instruction writes rd.
- `source_reg1`, `source_reg2` in `REGISTER_SIZE`: decode rs1, rs2.
- `rs1_used`, `rs2_used` in 1: operand actually read.
- `dm_read_enable` in 1: decode instruction is a load.
- `flush` in 1: squash decode instruction (branch taken).
- `pipeline_hold` in 1: global freeze (e.g. memory wait).
- `f_to_d_enable_ff` out 1: fetch-to-decode register enable.
- `d_to_e_enable_ff` out 1: decode-to-execute register enable.
- `d_to_e_bubble` out 1: decode-to-execute register loads NOP.
- `fwd_stage_a`, `fwd_stage_b` out `STAGE_W`: 0 = register file, k = stage k.
- `fwd_load_a`, `fwd_load_b` out 1: 1 = data-memory read data of stage k, 0 = ALU result of stage k.
- `stall_count` out `COUNT_W`: load-use stall cycles.

## Operation
History is `hist[1..FWD_DEPTH]`. Each entry holds {valid, rd, wr_en, is_load}.

Producer match for operand X at stage k requires all of:
- `hist[k].valid`
- `hist[k].wr_en`
- `hist[k].rd` ≠ 0
- `hist[k].rd` == rsX
- rsX_used
- `decode_valid`

Forwarding select:
- Search k = 1..`FWD_DEPTH`; the smallest matching k wins.
- No match: `fwd_stage`=0, `fwd_load`=0.
- Match found: `fwd_stage`=k, `fwd_load`=`hist[k].is_load`.

Load-use stall:
- Triggered when the winning match for either operand is a load with k < `LOAD_STAGE`, and `flush`=0.
- Outputs during a stall: `f_to_d_enable_ff`=0, `d_to_e_enable_ff`=1, `d_to_e_bubble`=1.
- The stalled operand's `fwd_*` outputs are don't-care.

`pipeline_hold`=1:
- `f_to_d_enable_ff`=0, `d_to_e_enable_ff`=0, `d_to_e_bubble`=0.
- History frozen.

Shift rule, applied when `pipeline_hold`=0:
- `hist[k+1]` ← `hist[k]`.
- `hist[1]` ← bubble (all fields 0) if stall or `flush` or !`decode_valid`; otherwise {1, `destination_reg`, `rd_write_en`, `dm_read_enable`}.

Simultaneous events:
- `flush` and `pipeline_hold` together: `flush` suppresses the stall; hold still freezes history, and `flush` must be held until hold drops.
- Stall and `flush` together: `flush` wins, no stall, no count.

## Timing
- Outputs are combinational from decode inputs plus registered history; zero-cycle latency.
- History updates on `posedge clk`.
- Reset values (history all invalid, counter 0): `f_to_d_enable_ff`=1, `d_to_e_enable_ff`=1, `d_to_e_bubble`=0, `fwd_stage_*`=0, `fwd_load_*`=0, `stall_count`=0.
- Load-use stall length is `LOAD_STAGE`−k cycles; the bubble advances through history naturally, so no separate state machine is needed.
- `rst` mid-stall clears history; the next cycle shows no stall.
- `stall_count` increments on cycles where a stall is asserted and `pipeline_hold`=0. It saturates at all-ones (no wrap).

## Configuration
- `HAZARD_STALL_COUNTER_EN` defined: the counter is implemented as described in Timing.
- `HAZARD_STALL_COUNTER_EN` undefined: no counter flops; `stall_count` tied to 0.

## Test plan
All scenarios use default parameters.
- **ALU forward:** add x5 at cycle n; at n+1 decode add x6,x5,x0 → `fwd_stage_a`=1, `fwd_load_a`=0, `fwd_stage_b`=0, no stall.
- **Load-use:** lw x7 at cycle n; at n+1 decode add x8,x7,x7 →
  - n+1: `f_to_d_enable_ff`=0, `d_to_e_bubble`=1.
  - n+2: `fwd_stage_a`=`fwd_stage_b`=2, `fwd_load_a`=`fwd_load_b`=1, no stall.
  - `stall_count`=1.
- **x0 and write-enable filtering:** producer writes x0, or sw with rd field=5 and `rd_write_en`=0; then read x0 or x5 → `fwd_stage`=0, no stall.
- **Youngest priority:** add x5 at cycles n and n+1; read x5 at n+2 → `fwd_stage_a`=1, not 2.
- **Flush:** lw x7 in decode with `flush`=1; next cycle read x7 → no stall, `fwd_stage_a`=0, `stall_count` unchanged.
- **Hold and reset:**
  - Producer x9 at stage 1, then `pipeline_hold`=1 for 3 cycles → `fwd_stage_a`=1 throughout.
  - Release hold → 2 next cycle.
  - Assert `rst` during a load-use stall → next cycle all outputs at reset values.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// Data-hazard unit beside decode: operand forwarding selection and load-use stall.
// Optional stall counter is built when HAZARD_STALL_COUNTER_EN is defined.
module forwarding_hazard_unit #(
  parameter int REGISTER_SIZE = 5,
  parameter int FWD_DEPTH     = 3,
  parameter int LOAD_STAGE    = 2,
  parameter int COUNT_W       = 16,
  localparam int STAGE_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     decode_valid,
  input  logic [REGISTER_SIZE-1:0] destination_reg,
  input  logic                     rd_write_en,
  input  logic [REGISTER_SIZE-1:0] source_reg1,
  input  logic [REGISTER_SIZE-1:0] source_reg2,
  input  logic                     rs1_used,
  input  logic                     rs2_used,
  input  logic                     dm_read_enable,
  input  logic                     flush,
  input  logic                     pipeline_hold,
  output logic                     f_to_d_enable_ff,
  output logic                     d_to_e_enable_ff,
  output logic                     d_to_e_bubble,
  output logic [STAGE_W-1:0]       fwd_stage_a,
  output logic [STAGE_W-1:0]       fwd_stage_b,
  output logic                     fwd_load_a,
  output logic                     fwd_load_b,
  output logic [COUNT_W-1:0]       stall_count
);

  typedef struct packed {
    logic                     valid;
    logic [REGISTER_SIZE-1:0] rd;
    logic                     wr_en;
    logic                     is_load;
  } hist_t;

  // hist[1] is execute, hist[FWD_DEPTH] the oldest tracked stage.
  hist_t hist [1:FWD_DEPTH];

  logic stall_a;
  logic stall_b;
  logic stall;

  function automatic logic producer_match(input hist_t h,
                                          input logic [REGISTER_SIZE-1:0] rs,
                                          input logic used);
    return h.valid && h.wr_en && (h.rd != '0) && (h.rd == rs) && used && decode_valid;
  endfunction

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    fwd_stage_a = '0;
    fwd_load_a  = 1'b0;
    fwd_stage_b = '0;
    fwd_load_b  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (producer_match(hist[k], source_reg1, rs1_used)) begin
        fwd_stage_a = STAGE_W'(k);
        fwd_load_a  = hist[k].is_load;
      end
      if (producer_match(hist[k], source_reg2, rs2_used)) begin
        fwd_stage_b = STAGE_W'(k);
        fwd_load_b  = hist[k].is_load;
      end
    end
  end

  // fwd_load_* is only set on a match, so a nonzero stage is implied.
  assign stall_a = fwd_load_a && (int'(fwd_stage_a) < LOAD_STAGE);
  assign stall_b = fwd_load_b && (int'(fwd_stage_b) < LOAD_STAGE);
  assign stall   = (stall_a || stall_b) && !flush;

  always_comb begin
    f_to_d_enable_ff = 1'b1;
    d_to_e_enable_ff = 1'b1;
    d_to_e_bubble    = 1'b0;
    if (pipeline_hold) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_enable_ff = 1'b0;
    end else if (stall) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_bubble    = 1'b1;
    end
  end

  // The stall bubble shifts through history like any instruction, so the
  // stall releases on its own once the load reaches LOAD_STAGE.
  always_ff @(posedge clk) begin
    // NOTE: history is a handful of flops, not a RAM; valid bits must clear on reset.
    if (rst) begin
      for (int k = 1; k <= FWD_DEPTH; k++) hist[k] <= '0;
    end else if (!pipeline_hold) begin
      // NOTE: non-blocking assignment makes the shift read the pre-edge values.
      if (stall || flush || !decode_valid) hist[1] <= '0;
      else hist[1] <= {1'b1, destination_reg, rd_write_en, dm_read_enable};
      for (int k = 2; k <= FWD_DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else if (stall && !pipeline_hold && (count_q != '1)) count_q <= count_q + 1'b1;
  end

  assign stall_count = count_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed scenarios then random
// traffic, compared against a queue-based model of the pipeline history.
module tb_forwarding_hazard_unit;
  localparam int LOAD_STAGE = 2;
  localparam int DEPTH      = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       decode_valid;
  logic [4:0] destination_reg;
  logic       rd_write_en;
  logic [4:0] source_reg1;
  logic [4:0] source_reg2;
  logic       rs1_used;
  logic       rs2_used;
  logic       dm_read_enable;
  logic       flush;
  logic       pipeline_hold;
  logic       f_to_d_enable_ff;
  logic       d_to_e_enable_ff;
  logic       d_to_e_bubble;
  logic [1:0] fwd_stage_a;
  logic [1:0] fwd_stage_b;
  logic       fwd_load_a;
  logic       fwd_load_b;
  logic [15:0] stall_count;

  forwarding_hazard_unit dut (
    .clk(clk), .rst(rst), .decode_valid(decode_valid),
    .destination_reg(destination_reg), .rd_write_en(rd_write_en),
    .source_reg1(source_reg1), .source_reg2(source_reg2),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .dm_read_enable(dm_read_enable), .flush(flush), .pipeline_hold(pipeline_hold),
    .f_to_d_enable_ff(f_to_d_enable_ff), .d_to_e_enable_ff(d_to_e_enable_ff),
    .d_to_e_bubble(d_to_e_bubble), .fwd_stage_a(fwd_stage_a), .fwd_stage_b(fwd_stage_b),
    .fwd_load_a(fwd_load_a), .fwd_load_b(fwd_load_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } ent_t;

  ent_t q[$];          // q[0] = stage 1 (execute)
  int   m_cnt;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
`ifdef HAZARD_STALL_COUNTER_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    ent_t e;
    e = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(e);
    m_cnt = 0;
  endtask

  // Youngest producer the decode operand depends on; 0 means register file.
  task automatic ref_op(input int rs, input bit used, output int stg, output bit ld);
    stg = 0;
    ld  = 1'b0;
    if (used && decode_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].v && q[i].wr && q[i].rd != 0 && q[i].rd == rs) begin
          stg = i + 1;
          ld  = q[i].ld;
          break;
        end
      end
    end
  endtask

  task automatic drive(input bit dv, input int rd, input bit we, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2);
    decode_valid    = dv;
    destination_reg = 5'(rd);
    rd_write_en     = we;
    dm_read_enable  = ld;
    source_reg1     = 5'(rs1);
    rs1_used        = u1;
    source_reg2     = 5'(rs2);
    rs2_used        = u2;
  endtask

  // Compare every output against the model, then clock once and advance the model.
  task automatic cycle(input string tag);
    int sa, sb;
    bit la, lb, sta, stb, stl;
    int e_fd, e_de, e_bub;
    ent_t e;
    #1;
    ref_op(int'(source_reg1), rs1_used, sa, la);
    ref_op(int'(source_reg2), rs2_used, sb, lb);
    sta = (sa != 0) && la && (sa < LOAD_STAGE);
    stb = (sb != 0) && lb && (sb < LOAD_STAGE);
    stl = (sta || stb) && !flush;
    if (pipeline_hold) begin e_fd = 0; e_de = 0; e_bub = 0; end
    else if (stl)      begin e_fd = 0; e_de = 1; e_bub = 1; end
    else               begin e_fd = 1; e_de = 1; e_bub = 0; end
    chk({tag, ".f_to_d"}, 32'(f_to_d_enable_ff), e_fd);
    chk({tag, ".d_to_e"}, 32'(d_to_e_enable_ff), e_de);
    chk({tag, ".bubble"}, 32'(d_to_e_bubble), e_bub);
    if (!(stl && sta)) begin
      chk({tag, ".stage_a"}, 32'(fwd_stage_a), sa);
      chk({tag, ".load_a"}, 32'(fwd_load_a), 32'(la));
    end
    if (!(stl && stb)) begin
      chk({tag, ".stage_b"}, 32'(fwd_stage_b), sb);
      chk({tag, ".load_b"}, 32'(fwd_load_b), 32'(lb));
    end
    chk({tag, ".count"}, 32'(stall_count), exp_count());
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!pipeline_hold) begin
      if (stl && m_cnt != 16'hFFFF) m_cnt++;
      if (stl || flush || !decode_valid) e = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
      else e = '{v: 1'b1, rd: int'(destination_reg), wr: rd_write_en, ld: dm_read_enable};
      q.push_front(e);
      void'(q.pop_back());
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    pipeline_hold = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();

    // Reset values
    #1;
    chk("reset.f_to_d", 32'(f_to_d_enable_ff), 1);
    chk("reset.bubble", 32'(d_to_e_bubble), 0);
    chk("reset.stage_a", 32'(fwd_stage_a), 0);
    chk("reset.count", 32'(stall_count), 0);
    cycle("reset");
    rst = 1'b0;

    // ALU forward: add x5, then add x6,x5,x0
    drive(1, 5, 1, 0, 1, 1, 2, 1);
    cycle("alu_prod");
    drive(1, 6, 1, 0, 5, 1, 0, 1);
    #1;
    chk("alu.stage_a", 32'(fwd_stage_a), 1);
    chk("alu.load_a", 32'(fwd_load_a), 0);
    chk("alu.stage_b", 32'(fwd_stage_b), 0);
    chk("alu.no_stall", 32'(f_to_d_enable_ff), 1);
    cycle("alu_use");

    // Load-use: lw x7, then add x8,x7,x7 held across the stall
    drive(1, 7, 1, 1, 0, 0, 0, 0);
    cycle("lu_prod");
    drive(1, 8, 1, 0, 7, 1, 7, 1);
    #1;
    chk("lu.stall_fd", 32'(f_to_d_enable_ff), 0);
    chk("lu.stall_bub", 32'(d_to_e_bubble), 1);
    cycle("lu_stall");
    #1;
    chk("lu.stage_a", 32'(fwd_stage_a), 2);
    chk("lu.stage_b", 32'(fwd_stage_b), 2);
    chk("lu.load_a", 32'(fwd_load_a), 1);
    chk("lu.load_b", 32'(fwd_load_b), 1);
    chk("lu.released", 32'(f_to_d_enable_ff), 1);
`ifdef HAZARD_STALL_COUNTER_EN
    chk("lu.count", 32'(stall_count), 1);
`else
    chk("lu.count", 32'(stall_count), 0);
`endif
    cycle("lu_fwd");

    // x0 producer and store with rd field 5 but no write
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    cycle("x0_prod");
    drive(1, 5, 0, 0, 1, 1, 2, 1);
    cycle("sw_prod");
    drive(1, 9, 1, 0, 0, 1, 5, 1);
    #1;
    chk("filt.stage_a", 32'(fwd_stage_a), 0);
    chk("filt.stage_b", 32'(fwd_stage_b), 0);
    chk("filt.no_stall", 32'(d_to_e_bubble), 0);
    cycle("filt_use");

    // Youngest priority
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    cycle("young_p1");
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    cycle("young_p2");
    drive(1, 0, 0, 0, 5, 1, 0, 0);
    #1;
    chk("young.stage_a", 32'(fwd_stage_a), 1);
    cycle("young_use");

    // Flushed load must not produce a stall next cycle
    flush = 1'b1;
    drive(1, 7, 1, 1, 0, 0, 0, 0);
    cycle("flush_lw");
    flush = 1'b0;
    drive(1, 0, 0, 0, 7, 1, 0, 0);
    #1;
    chk("flush.no_stall", 32'(f_to_d_enable_ff), 1);
    chk("flush.stage_a", 32'(fwd_stage_a), 0);
    cycle("flush_use");

    // Hold freezes history
    drive(1, 9, 1, 0, 0, 0, 0, 0);
    cycle("hold_prod");
    pipeline_hold = 1'b1;
    drive(1, 0, 0, 0, 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.stage_a", 32'(fwd_stage_a), 1);
      chk("hold.d_to_e", 32'(d_to_e_enable_ff), 0);
      cycle("hold");
    end
    pipeline_hold = 1'b0;
    cycle("hold_release");
    #1;
    chk("hold.after", 32'(fwd_stage_a), 2);
    cycle("hold_after");

    // Reset during a load-use stall
    drive(1, 7, 1, 1, 0, 0, 0, 0);
    cycle("rs_prod");
    drive(1, 8, 1, 0, 7, 1, 0, 0);
    #1;
    chk("rst_stall.bubble", 32'(d_to_e_bubble), 1);
    rst = 1'b1;
    cycle("rst_stall");
    rst = 1'b0;
    #1;
    chk("rst_after.f_to_d", 32'(f_to_d_enable_ff), 1);
    chk("rst_after.bubble", 32'(d_to_e_bubble), 0);
    chk("rst_after.stage_a", 32'(fwd_stage_a), 0);
    chk("rst_after.count", 32'(stall_count), 0);
    cycle("rst_after");

    // Random traffic over a small register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1) != 0);
      flush         = ($urandom_range(0, 7) == 0);
      pipeline_hold = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end
    rst = 1'b0;
    flush = 1'b0;
    pipeline_hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
